// File: rtl/pipelined_control_unit.sv
// ID-stage control decoder that registers the control bundle into ID/EX, with
// stall/flush/bubble handling, load-use hazard detection and illegal-opcode flagging.
module pipelined_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter bit HAZARD_EN  = 1'b1,
  parameter bit JAL_LINK   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPCODE_W-1:0]   OpCode,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic                  in_valid,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic                  RegDst,
  output logic                  Jump,
  output logic                  Branch,
  output logic                  MemRead,
  output logic                  MemtoReg,
  output logic                  MemWrite,
  output logic                  ALUSrc,
  output logic                  RegWrite,
  output logic                  JAL,
  output logic [ALUOP_W-1:0]    ALUOp,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  illegal_op,
  output logic                  hazard_stall
);

  // Opcodes are compared zero-extended to OPCODE_W.
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);

  typedef struct packed {
    logic                  reg_dst;
    logic                  jump;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic                  jal;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  valid;
    logic [REG_ADDR_W-1:0] rt;
  } ctrl_t;

  ctrl_t ex_q;
  ctrl_t dec;
  logic  dec_legal;
  logic  uses_rt;
  logic  illegal_q;

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    uses_rt   = 1'b0;
    case (OpCode)
      OP_R: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(2'b10);
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_W'(2'b01);
        uses_rt    = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_J:    dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.jal       = 1'b1;
        dec.reg_write = JAL_LINK;
      end
      default: dec_legal = 1'b0;
    endcase
    dec.valid = 1'b1;
    dec.rt    = Rt;
  end

  // Load in EX whose destination feeds the ID instruction: freeze PC/IF-ID and bubble EX.
  assign hazard_stall = HAZARD_EN && in_valid && ex_q.valid && ex_q.mem_read &&
                        (ex_q.rt != '0) &&
                        ((ex_q.rt == Rs) || (uses_rt && (ex_q.rt == Rt)));

  // Handshake: in_valid marks a real ID instruction; ex_valid marks a real ID/EX
  // instruction. stall_ext holds ID/EX; flush and hazard_stall replace it with a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else if (stall_ext) begin
      illegal_q <= 1'b0;
    end else if (hazard_stall || !in_valid) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else if (!dec_legal) begin
      ex_q      <= '0;
      illegal_q <= 1'b1;
    end else begin
      ex_q      <= dec;
      illegal_q <= 1'b0;
    end
  end

  assign RegDst     = ex_q.reg_dst;
  assign Jump       = ex_q.jump;
  assign Branch     = ex_q.branch;
  assign MemRead    = ex_q.mem_read;
  assign MemtoReg   = ex_q.mem_to_reg;
  assign MemWrite   = ex_q.mem_write;
  assign ALUSrc     = ex_q.alu_src;
  assign RegWrite   = ex_q.reg_write;
  assign JAL        = ex_q.jal;
  assign ALUOp      = ex_q.alu_op;
  assign ex_valid   = ex_q.valid;
  assign ex_rt      = ex_q.rt;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: driver pushes expected ID/EX bundles,
// a monitor pops and compares them after every rising edge.
module tb_pipelined_control_unit;

  localparam int W = 18;  // {ctrl[8:0], aluop[1:0], ex_valid, ex_rt[4:0], illegal_op}

  // ctrl order: {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JAL}
  localparam logic [8:0] C_R    = 9'b100000010;
  localparam logic [8:0] C_LW   = 9'b000110110;
  localparam logic [8:0] C_SW   = 9'b000001100;
  localparam logic [8:0] C_BEQ  = 9'b001000000;
  localparam logic [8:0] C_ADDI = 9'b000000110;
  localparam logic [8:0] C_J    = 9'b010000000;
  localparam logic [8:0] C_JAL  = 9'b010000011;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010,
                         O_JAL = 6'b000011, O_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] rs = '0, rt = '0;
  logic       in_valid = 1'b0, stall_ext = 1'b0, flush = 1'b0;

  logic       reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jal;
  logic [1:0] alu_op;
  logic       ex_valid, illegal_op, hazard_stall;
  logic [4:0] ex_rt;

  logic       n_reg_dst, n_jump, n_branch, n_mem_read, n_mem_to_reg, n_mem_write;
  logic       n_alu_src, n_reg_write, n_jal, n_ex_valid, n_illegal_op, n_hazard_stall;
  logic [1:0] n_alu_op;
  logic [4:0] n_ex_rt;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pipelined_control_unit dut (
    .CLK(clk), .RST(rst), .OpCode(opcode), .Rs(rs), .Rt(rt), .in_valid(in_valid),
    .stall_ext(stall_ext), .flush(flush),
    .RegDst(reg_dst), .Jump(jump), .Branch(branch), .MemRead(mem_read),
    .MemtoReg(mem_to_reg), .MemWrite(mem_write), .ALUSrc(alu_src),
    .RegWrite(reg_write), .JAL(jal), .ALUOp(alu_op), .ex_valid(ex_valid),
    .ex_rt(ex_rt), .illegal_op(illegal_op), .hazard_stall(hazard_stall)
  );

  pipelined_control_unit #(.HAZARD_EN(1'b0)) dut_nh (
    .CLK(clk), .RST(rst), .OpCode(opcode), .Rs(rs), .Rt(rt), .in_valid(in_valid),
    .stall_ext(stall_ext), .flush(flush),
    .RegDst(n_reg_dst), .Jump(n_jump), .Branch(n_branch), .MemRead(n_mem_read),
    .MemtoReg(n_mem_to_reg), .MemWrite(n_mem_write), .ALUSrc(n_alu_src),
    .RegWrite(n_reg_write), .JAL(n_jal), .ALUOp(n_alu_op), .ex_valid(n_ex_valid),
    .ex_rt(n_ex_rt), .illegal_op(n_illegal_op), .hazard_stall(n_hazard_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic [8:0] c, input logic [1:0] aop,
                                      input logic v, input logic [4:0] r, input logic ill);
    return {c, aop, v, r, ill};
  endfunction

  // monitor: compare the ID/EX bundle after every edge that has an expectation
  always @(posedge clk) begin
    logic [W-1:0] act, exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src,
             reg_write, jal, alu_op, ex_valid, ex_rt, illegal_op};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL bundle t=%0t got=%b want=%b", $time, act, exp);
      end
    end
  end

  // driver: present one ID-stage cycle, check hazard_stall, queue the post-edge bundle
  task automatic step(input logic r, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic iv, input logic st, input logic fl,
                      input logic [W-1:0] exp, input logic exp_haz);
    @(negedge clk);
    rst = r; opcode = op; rs = s; rt = t; in_valid = iv; stall_ext = st; flush = fl;
    #1;
    n_tests++;
    if (hazard_stall !== exp_haz) begin
      n_fail++;
      $display("FAIL hazard_stall t=%0t got=%b want=%b", $time, hazard_stall, exp_haz);
    end
    n_tests++;
    if (n_hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_stall_disabled t=%0t got=%b want=0", $time, n_hazard_stall);
    end
    exp_q.push_back(exp);
  endtask

  initial begin
    // reset
    step(1, O_R, 0, 0, 0, 0, 0, '0, 0);
    step(1, O_R, 0, 0, 1, 0, 0, '0, 0);
    // full decode table
    step(0, O_R,    1, 2, 1, 0, 0, ev(C_R,    2'b10, 1, 2, 0), 0);
    step(0, O_LW,   1, 3, 1, 0, 0, ev(C_LW,   2'b00, 1, 3, 0), 0);
    step(0, O_SW,   1, 4, 1, 0, 0, ev(C_SW,   2'b00, 1, 4, 0), 0);
    step(0, O_BEQ,  1, 5, 1, 0, 0, ev(C_BEQ,  2'b01, 1, 5, 0), 0);
    step(0, O_ADDI, 1, 6, 1, 0, 0, ev(C_ADDI, 2'b00, 1, 6, 0), 0);
    step(0, O_J,    1, 7, 1, 0, 0, ev(C_J,    2'b00, 1, 7, 0), 0);
    step(0, O_JAL,  1, 8, 1, 0, 0, ev(C_JAL,  2'b00, 1, 8, 0), 0);
    // load-use on Rs
    step(0, O_LW,   1, 8, 1, 0, 0, ev(C_LW,   2'b00, 1, 8, 0), 0);
    step(0, O_R,    8, 2, 1, 0, 0, '0, 1);
    step(0, O_R,    8, 2, 1, 0, 0, ev(C_R,    2'b10, 1, 2, 0), 0);
    // load-use on Rt for a store
    step(0, O_LW,   1, 9, 1, 0, 0, ev(C_LW,   2'b00, 1, 9, 0), 0);
    step(0, O_SW,   3, 9, 1, 0, 0, '0, 1);
    step(0, O_SW,   3, 9, 1, 0, 0, ev(C_SW,   2'b00, 1, 9, 0), 0);
    // no hazard: $0 destination, and lw does not read Rt
    step(0, O_LW,   1, 0, 1, 0, 0, ev(C_LW,   2'b00, 1, 0, 0), 0);
    step(0, O_R,    0, 0, 1, 0, 0, ev(C_R,    2'b10, 1, 0, 0), 0);
    step(0, O_LW,   1, 9, 1, 0, 0, ev(C_LW,   2'b00, 1, 9, 0), 0);
    step(0, O_LW,   3, 9, 1, 0, 0, ev(C_LW,   2'b00, 1, 9, 0), 0);
    // hazard seen by the enabled instance only
    step(0, O_LW,   1, 8, 1, 0, 0, ev(C_LW,   2'b00, 1, 8, 0), 0);
    step(0, O_R,    8, 2, 1, 0, 0, '0, 1);
    step(0, O_R,    8, 2, 1, 0, 0, ev(C_R,    2'b10, 1, 2, 0), 0);
    // external stall holds sw, then flush beats stall
    step(0, O_SW,   1, 4, 1, 0, 0, ev(C_SW,   2'b00, 1, 4, 0), 0);
    step(0, O_LW,   1, 4, 1, 1, 0, ev(C_SW,   2'b00, 1, 4, 0), 0);
    step(0, O_BAD,  2, 5, 1, 1, 0, ev(C_SW,   2'b00, 1, 4, 0), 0);
    step(0, O_BEQ,  3, 6, 1, 1, 0, ev(C_SW,   2'b00, 1, 4, 0), 0);
    step(0, O_R,    1, 2, 1, 1, 1, '0, 0);
    // illegal opcode, then a valid add
    step(0, O_BAD,  1, 5, 1, 0, 0, ev(9'b0,   2'b00, 0, 0, 1), 0);
    step(0, O_R,    1, 2, 1, 0, 0, ev(C_R,    2'b10, 1, 2, 0), 0);
    // in_valid low and flush alone both bubble
    step(0, O_LW,   1, 3, 0, 0, 0, '0, 0);
    step(0, O_ADDI, 1, 6, 1, 0, 1, '0, 0);
    // reset mid-stream discards a load; hazard output is still combinational
    step(0, O_LW,   1, 8, 1, 0, 0, ev(C_LW,   2'b00, 1, 8, 0), 0);
    step(1, O_R,    8, 2, 1, 0, 0, '0, 1);
    step(0, O_R,    8, 2, 1, 0, 0, ev(C_R,    2'b10, 1, 2, 0), 0);
    // an invalid ID slot never raises a hazard
    step(0, O_LW,   1, 8, 1, 0, 0, ev(C_LW,   2'b00, 1, 8, 0), 0);
    step(0, O_R,    8, 2, 0, 0, 0, '0, 0);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Successor to the single-stage MIPS control decoder. It decodes the ID-stage opcode and registers the full control bundle into the ID/EX pipeline stage, with a valid bit. It adds stall, flush and bubble insertion, built-in load-use hazard detection and illegal-opcode flagging. It sits between the IF/ID register and the EX stage of the 5-stage pipeline.

Parameters:
OPCODE_W, 6, opcode field width; must be >= 6; opcodes are compared zero-extended
REG_ADDR_W, 5, register-specifier width
ALUOP_W, 2, ALUOp width; must be >= 2; upper bits are zero
HAZARD_EN, 1, 1 = load-use detection active; 0 = hazard_stall tied 0
JAL_LINK, 1, 1 = jal sets RegWrite=1 (link write to $31); 0 = RegWrite=0 for jal

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
OpCode  in  OPCODE_W  ID-stage opcode
Rs  in  REG_ADDR_W  ID-stage rs field
Rt  in  REG_ADDR_W  ID-stage rt field
in_valid  in  1  ID stage holds a real instruction
stall_ext  in  1  downstream stall; hold ID/EX contents
flush  in  1  kill ID-stage instruction (taken branch/jump)
RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JAL  out  1 each  registered ID/EX controls
ALUOp  out  ALUOP_W  registered ID/EX ALU op class
ex_valid  out  1  ID/EX holds a real instruction
ex_rt  out  REG_ADDR_W  registered Rt of the ID/EX instruction
illegal_op  out  1  registered; 1 for one cycle when an undefined valid opcode was dropped
hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- Reset (RST high at an edge): every registered output is 0, including ex_valid, ex_rt and illegal_op. RST overrides all other inputs. Reset mid-stream discards the ID/EX instruction.
- Latency: 1 cycle. Controls for the instruction presented in cycle N appear after edge N+1.
- Bubble: all controls 0, ALUOp 0, ex_valid 0, ex_rt 0.
- Per-edge priority: RST > flush > stall_ext > hazard_stall > decode.
  - flush: load a bubble, even when stall_ext=1.
  - stall_ext: hold all registers. illegal_op is cleared to 0.
  - hazard_stall: load a bubble.
  - Otherwise: if in_valid=0, load a bubble. Else decode.
- hazard_stall = HAZARD_EN & in_valid & ex_valid & MemRead & (ex_rt != 0) & (ex_rt==Rs | (uses_rt & ex_rt==Rt)).
  - uses_rt = 1 for R-type, sw and beq.
  - hazard_stall is purely combinational from the current inputs and registers. It is not gated by flush or stall_ext.
- Decode table. Fields listed are 1; every unlisted field is 0.
  - 000000 R-type: RegDst, RegWrite, ALUOp=10
  - 100011 lw: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00
  - 101011 sw: ALUSrc, MemWrite, ALUOp=00
  - 000100 beq: Branch, ALUOp=01
  - 001000 addi: ALUSrc, RegWrite, ALUOp=00
  - 000010 j: Jump
  - 000011 jal: Jump, JAL, plus RegWrite iff JAL_LINK
- For every decoded instruction: ex_valid=1 and ex_rt=Rt.
- Undefined opcode with in_valid=1 (decode path): load a bubble and set illegal_op=1 for one cycle.
- illegal_op is 0 after any edge that does not drop an illegal instruction.
- Nothing is latched on the negative edge, and no output is left unassigned. The block contains no latches.

Test Plan:
- Reset, then OpCode sequence 000000, 100011, 101011, 000100, 001000, 000010, 000011 with in_valid=1 and no stalls -> each bundle matches the table one cycle later. jal gives RegWrite=1 (JAL_LINK=1). ex_valid=1 throughout.
- lw with Rt=8, then next cycle R-type with Rs=8 -> hazard_stall=1 that cycle and a bubble follows (ex_valid=0). The cycle after that, the R-type decodes (RegDst=1, ALUOp=10).
- lw with Rt=0 followed by Rs=0; and lw Rt=9 followed by lw with Rt=9, Rs=3 -> hazard_stall=0 in both cases. With HAZARD_EN=0, lw Rt=8 then R-type Rs=8 -> hazard_stall=0.
- Load sw, then assert stall_ext for 3 cycles with changing OpCode -> outputs hold the sw bundle. Assert flush together with stall_ext -> bubble on the next edge.
- OpCode 111111 with in_valid=1 -> next edge: illegal_op=1 and bubble. Following edge with a valid add -> illegal_op=0 and R-type bundle.
- lw in ID/EX, then RST high for one edge -> all outputs 0. The next instruction decodes normally with no spurious hazard.
